// File: rtl/regfile_pkg.sv
// regfile_pkg: types and defaults shared by the register file and its scoreboard.
//   clr_state_e  : clear FSM states, IDLE (StIdle) and CLEAR (StClear)
//   XlenDefault  : default data width
//   NregDefault  : default register count
package regfile_pkg;

  localparam int unsigned XlenDefault = 32;
  localparam int unsigned NregDefault = 32;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StClear = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one pending-write (busy) bit per register.
//   CLK, RST_N           : clock, async active-low reset (clears all bits)
//   FLUSH                : clear every bit on the next edge (overrides everything)
//   SET_EN, SET_IDX      : mark a register pending
//   CLR_A_EN, CLR_A_IDX  : write port A retires a register
//   CLR_B_EN, CLR_B_IDX  : write port B retires a register
//   RA1, RA2             : lookup addresses
//   BUSY1, BUSY2         : busy bit of RA1 / RA2
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREG = NregDefault,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          FLUSH,
  input  logic          SET_EN,
  input  logic [AW-1:0] SET_IDX,
  input  logic          CLR_A_EN,
  input  logic [AW-1:0] CLR_A_IDX,
  input  logic          CLR_B_EN,
  input  logic [AW-1:0] CLR_B_IDX,
  input  logic [AW-1:0] RA1,
  input  logic [AW-1:0] RA2,
  output logic          BUSY1,
  output logic          BUSY2
);

  logic [NREG-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (FLUSH) begin
      busy_d = '0;
    end else begin
      if (CLR_A_EN) busy_d[CLR_A_IDX] = 1'b0;
      if (CLR_B_EN) busy_d[CLR_B_IDX] = 1'b0;
      // Set is applied last so an issue wins over a same-cycle write.
      if (SET_EN)   busy_d[SET_IDX]   = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign BUSY1 = busy_q[RA1];
  assign BUSY2 = busy_q[RA2];

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2-read / 2-write register file with scoreboard and a clearing sweep.
//   CLK, RST_N           : clock, async active-low reset (restarts the clear sweep)
//   RA1/RA2 -> RD1/RD2   : combinational reads, x0 reads 0
//   BUSY1, BUSY2         : scoreboard bit of RA1 / RA2
//   WE3/WA3/WD3          : write port A (wins on address conflict)
//   WE4/WA4/WD4          : write port B
//   ISS_VALID, ISS_RD    : mark ISS_RD pending-write
//   CLR_REQ              : start a sweep that zeroes x1..x(NREG-1)
//   CLR_BUSY             : high while the sweep runs
//   DISP_DATA            : live value of register DISP_IDX
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to the
// read ports (WD3 first), with BUSY reading 0 for a forwarded address.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XlenDefault,
  parameter int unsigned NREG     = NregDefault,
  parameter int unsigned DISP_IDX = 4,
  localparam int unsigned AW      = $clog2(NREG)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [AW-1:0]   RA1,
  input  logic [AW-1:0]   RA2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic            BUSY1,
  output logic            BUSY2,
  input  logic            WE3,
  input  logic [AW-1:0]   WA3,
  input  logic [XLEN-1:0] WD3,
  input  logic            WE4,
  input  logic [AW-1:0]   WA4,
  input  logic [XLEN-1:0] WD4,
  input  logic            ISS_VALID,
  input  logic [AW-1:0]   ISS_RD,
  input  logic            CLR_REQ,
  output logic            CLR_BUSY,
  output logic [XLEN-1:0] DISP_DATA
);

  localparam logic [AW-1:0] LastIdx  = AW'(NREG - 1);
  localparam logic [AW-1:0] DispAddr = AW'(DISP_IDX);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          idle;

  logic          we3_ok, we4_ok, iss_ok;
  logic          sb_busy1, sb_busy2;

  logic [XLEN-1:0] rf_q  [NREG];
  logic [XLEN-1:0] rf_wd [NREG];
  logic [NREG-1:0] rf_we;

  assign idle     = (state_q == StIdle);
  assign CLR_BUSY = ~idle;

  // External writes and issues only count in IDLE and never to x0.
  assign we3_ok = WE3 && idle && (WA3 != '0);
  assign we4_ok = WE4 && idle && (WA4 != '0);
  assign iss_ok = ISS_VALID && idle && (ISS_RD != '0);

  // Clear FSM
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (CLR_REQ) begin
          state_d = StClear;
          idx_d   = AW'(1);
        end
      end
      StClear: begin
        if (idx_q == LastIdx) begin
          state_d = StIdle;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: begin
        state_d = StClear;
        idx_d   = AW'(1);
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StClear;
      idx_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Per-register write enables; port A is evaluated last so it wins a conflict.
  always_comb begin
    rf_we = '0;
    for (int i = 0; i < NREG; i++) begin
      rf_wd[i] = '0;
    end
    for (int i = 1; i < NREG; i++) begin
      if (!idle) begin
        if (idx_q == AW'(i)) begin
          rf_we[i] = 1'b1;
        end
      end else begin
        if (we4_ok && (WA4 == AW'(i))) begin
          rf_we[i] = 1'b1;
          rf_wd[i] = WD4;
        end
        if (we3_ok && (WA3 == AW'(i))) begin
          rf_we[i] = 1'b1;
          rf_wd[i] = WD3;
        end
      end
    end
  end

  // No reset on the array: the sweep is what zeroes it.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NREG; i++) begin
      if (rf_we[i]) rf_q[i] <= rf_wd[i];
    end
  end

  regfile_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .FLUSH     (~idle),
    .SET_EN    (iss_ok),
    .SET_IDX   (ISS_RD),
    .CLR_A_EN  (we3_ok),
    .CLR_A_IDX (WA3),
    .CLR_B_EN  (we4_ok),
    .CLR_B_IDX (WA4),
    .RA1       (RA1),
    .RA2       (RA2),
    .BUSY1     (sb_busy1),
    .BUSY2     (sb_busy2)
  );

  // Read ports: x0 and the whole sweep read as 0 / not busy.
  always_comb begin
    RD1   = '0;
    RD2   = '0;
    BUSY1 = 1'b0;
    BUSY2 = 1'b0;
    if (idle && (RA1 != '0)) begin
      RD1   = rf_q[RA1];
      BUSY1 = sb_busy1;
`ifdef REGFILE_BYPASS_EN
      if (we3_ok && (WA3 == RA1)) begin
        RD1   = WD3;
        BUSY1 = 1'b0;
      end else if (we4_ok && (WA4 == RA1)) begin
        RD1   = WD4;
        BUSY1 = 1'b0;
      end
`endif
    end
    if (idle && (RA2 != '0)) begin
      RD2   = rf_q[RA2];
      BUSY2 = sb_busy2;
`ifdef REGFILE_BYPASS_EN
      if (we3_ok && (WA3 == RA2)) begin
        RD2   = WD3;
        BUSY2 = 1'b0;
      end else if (we4_ok && (WA4 == RA2)) begin
        RD2   = WD4;
        BUSY2 = 1'b0;
      end
`endif
    end
  end

  assign DISP_DATA = (DispAddr == '0) ? '0 : rf_q[DispAddr];

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DISP = 4;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic [AW-1:0]   RA1, RA2, WA3, WA4, ISS_RD;
  logic [XLEN-1:0] RD1, RD2, WD3, WD4, DISP_DATA;
  logic            BUSY1, BUSY2, WE3, WE4, ISS_VALID, CLR_REQ, CLR_BUSY;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;
  int cyc;

  always #5 CLK = ~CLK;

  regfile_sb #(
    .XLEN     (XLEN),
    .NREG     (NREG),
    .DISP_IDX (DISP)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .RA1       (RA1),
    .RA2       (RA2),
    .RD1       (RD1),
    .RD2       (RD2),
    .BUSY1     (BUSY1),
    .BUSY2     (BUSY2),
    .WE3       (WE3),
    .WA3       (WA3),
    .WD3       (WD3),
    .WE4       (WE4),
    .WA4       (WA4),
    .WD4       (WD4),
    .ISS_VALID (ISS_VALID),
    .ISS_RD    (ISS_RD),
    .CLR_REQ   (CLR_REQ),
    .CLR_BUSY  (CLR_BUSY),
    .DISP_DATA (DISP_DATA)
  );

  // Reference model: register contents, busy flags and remaining sweep cycles.
  logic [XLEN-1:0] m_rf    [NREG];
  bit              m_known [NREG];
  bit              m_busy  [NREG];
  int              m_clr_left = NREG - 1;
  int              m_a;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_clr_left = NREG - 1;
      for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    end else if (m_clr_left > 0) begin
      m_a = NREG - m_clr_left;
      m_rf[m_a]    = '0;
      m_known[m_a] = 1'b1;
      m_clr_left   = m_clr_left - 1;
      for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    end else begin
      if (WE4 && WA4 != 0) begin
        m_rf[WA4] = WD4; m_known[WA4] = 1'b1; m_busy[WA4] = 1'b0;
      end
      if (WE3 && WA3 != 0) begin
        m_rf[WA3] = WD3; m_known[WA3] = 1'b1; m_busy[WA3] = 1'b0;
      end
      if (ISS_VALID && ISS_RD != 0) m_busy[ISS_RD] = 1'b1;
      if (CLR_REQ) m_clr_left = NREG - 1;
    end
  end

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
    if (m_clr_left > 0 || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (WE3 && WA3 == a) return WD3;
    if (WE4 && WA4 == a) return WD4;
`endif
    return m_rf[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (m_clr_left > 0 || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if ((WE3 && WA3 == a) || (WE4 && WA4 == a)) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("model_rd1", RD1, exp_rd(RA1));
      check("model_rd2", RD2, exp_rd(RA2));
      check("model_busy1", XLEN'(BUSY1), XLEN'(exp_busy(RA1)));
      check("model_busy2", XLEN'(BUSY2), XLEN'(exp_busy(RA2)));
      check("model_clr_busy", XLEN'(CLR_BUSY), XLEN'(m_clr_left > 0));
      if (m_known[DISP]) check("model_disp", DISP_DATA, m_rf[DISP]);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle_inputs();
    WE3 = 0; WA3 = 0; WD3 = 0; WE4 = 0; WA4 = 0; WD4 = 0;
    ISS_VALID = 0; ISS_RD = 0; CLR_REQ = 0;
  endtask

  // Counts edges until CLR_BUSY drops, bounded.
  task automatic wait_sweep(output int n);
    n = 0;
    while (CLR_BUSY && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    idle_inputs();
    RA1 = 0; RA2 = 0;
    RST_N = 0;
    repeat (3) tick();
    cmp_en = 1'b1;
    check("reset_clr_busy", XLEN'(CLR_BUSY), 1);

    // Writes, issues and clear requests during the sweep must be ignored.
    WE3 = 1; WA3 = 1; WD3 = 32'hDEAD;
    WE4 = 1; WA4 = 6; WD4 = 32'hBEEF;
    ISS_VALID = 1; ISS_RD = 2; CLR_REQ = 1;
    RST_N = 1;
    wait_sweep(cyc);
    idle_inputs();
    check("reset_sweep_len", cyc, 31);
    RA1 = 1; RA2 = 2; #1;
    check("swept_x1", RD1, 0);
    check("x2_not_busy", XLEN'(BUSY2), 0);
    RA1 = 6; #1;
    check("swept_x6", RD1, 0);

    // x0 and display register
    WE3 = 1; WA3 = 0; WD3 = 32'hFFFF; RA1 = 0;
    tick(); idle_inputs(); #1;
    check("x0_reads_zero", RD1, 0);
    WE3 = 1; WA3 = 4; WD3 = 32'hBEEF; #1;
    check("disp_before_edge", DISP_DATA, 0);
    tick(); idle_inputs(); #1;
    check("disp_after_edge", DISP_DATA, 32'hBEEF);

    // Dual-write conflict: port A wins
    WE3 = 1; WA3 = 5; WD3 = 32'hAAAA0000;
    WE4 = 1; WA4 = 5; WD4 = 32'h5555;
    tick(); idle_inputs(); RA1 = 5; #1;
    check("dual_write_x5", RD1, 32'hAAAA0000);
    WE4 = 1; WA4 = 6; WD4 = 32'h5555;
    tick(); idle_inputs(); RA2 = 6; #1;
    check("portb_write_x6", RD2, 32'h5555);

    // Scoreboard
    ISS_VALID = 1; ISS_RD = 7;
    tick(); idle_inputs(); RA1 = 7; #1;
    check("issue_sets_busy", XLEN'(BUSY1), 1);
    WE4 = 1; WA4 = 7; WD4 = 32'h70;
    tick(); idle_inputs(); #1;
    check("write_clears_busy", XLEN'(BUSY1), 0);
    check("write_x7_data", RD1, 32'h70);
    ISS_VALID = 1; ISS_RD = 7; WE3 = 1; WA3 = 7; WD3 = 32'h71;
    tick(); idle_inputs(); #1;
    check("issue_wins_busy", XLEN'(BUSY1), 1);

    // Bypass behaviour
    WE3 = 1; WA3 = 3; WD3 = 32'h1111;
    tick(); idle_inputs();
    WE3 = 1; WA3 = 3; WD3 = 32'h1234; RA1 = 3; #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_same_cycle", RD1, 32'h1234);
`else
    check("no_bypass_old", RD1, 32'h1111);
`endif
    tick(); idle_inputs(); #1;
    check("x3_after_edge", RD1, 32'h1234);
    WE3 = 1; WA3 = 8; WD3 = 32'h88; WE4 = 1; WA4 = 8; WD4 = 32'h99; RA2 = 8; #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_priority", RD2, 32'h88);
`else
    check("no_bypass_x8", RD2, 0);
`endif
    tick(); idle_inputs();

    // Mixed traffic, checked by the model every cycle
    for (int i = 1; i < 16; i++) begin
      WE3 = 1; WA3 = AW'(i);      WD3 = 32'h01010101 * i;
      WE4 = (i % 3) != 0; WA4 = AW'(i + 16); WD4 = ~(32'h00100010 * i);
      ISS_VALID = (i % 2) == 0; ISS_RD = AW'(i ^ 3);
      RA1 = AW'(i - 1); RA2 = AW'(i + 15);
      tick();
    end
    idle_inputs();
    RA1 = 9; RA2 = 25; tick();

    // Clear request, reset mid-sweep at index 10
    WE3 = 1; WA3 = 20; WD3 = 32'h77;
    tick(); idle_inputs(); RA2 = 20; #1;
    check("x20_written", RD2, 32'h77);
    CLR_REQ = 1;
    tick(); CLR_REQ = 0; #1;
    check("clr_req_starts", XLEN'(CLR_BUSY), 1);
    repeat (9) tick();
    RST_N = 0; #1;
    check("midclear_reset_busy", XLEN'(CLR_BUSY), 1);
    tick();
    RST_N = 1;
    wait_sweep(cyc);
    check("restart_sweep_len", cyc, 31);
    RA1 = 15; #1;
    check("x20_cleared", RD2, 0);
    check("x15_cleared", RD1, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
